// File: rtl/result_seg_display.sv
// Result display stage: sequential double-dabble binary-to-BCD conversion driving a
// 4-digit multiplexed active-low 7-segment display with leading-zero suppression.
module result_seg_display #(
  parameter int unsigned RESULT_W    = 9,
  parameter int unsigned REFRESH_DIV = 250000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [RESULT_W-1:0] result,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp,
  output logic [11:0]         bcd,
  output logic                bcd_valid,
  output logic                busy
);

  localparam int unsigned SH_W   = RESULT_W + 12;
  localparam int unsigned CNT_W  = $clog2(RESULT_W + 1);
  localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]  LastStep = CNT_W'(RESULT_W - 1);
  localparam logic [SCAN_W-1:0] ScanMax  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [6:0]        SegBlank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_t;

  state_t              state;
  logic [RESULT_W-1:0] last;
  logic [SH_W-1:0]     sh;
  logic [SH_W-1:0]     sh_adj;
  logic [CNT_W-1:0]    cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [1:0]          digit;
  logic [6:0]          seg_d;
  logic [3:0]          an_d;

  assign dp = 1'b1;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    unique case (nib)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble ahead of the shift.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < 3; i++) begin
      if (sh[RESULT_W + 4*i +: 4] >= 4'd5) begin
        sh_adj[RESULT_W + 4*i +: 4] = sh[RESULT_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      last      <= '0;
      sh        <= '0;
      cnt       <= '0;
      bcd       <= 12'h000;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (result != last) begin
            sh    <= {12'b0, result};
            last  <= result;
            cnt   <= '0;
            state <= StConv;
            busy  <= 1'b1;
          end
        end
        StConv: begin
          sh  <= sh_adj << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LastStep) begin
            state <= StDone;
          end
        end
        StDone: begin
          bcd       <= sh[RESULT_W +: 12];
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit 1 is blanked only when both hundreds and tens are zero.
  always_comb begin
    an_d  = ~(4'b0001 << digit);
    seg_d = SegBlank;
    unique case (digit)
      2'd0: seg_d = seg_of(bcd[3:0]);
      2'd1: seg_d = (bcd[11:4] == 8'h00) ? SegBlank : seg_of(bcd[7:4]);
      2'd2: seg_d = (bcd[11:8] == 4'h0) ? SegBlank : seg_of(bcd[11:8]);
      default: seg_d = SegBlank;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      an       <= 4'b1111;
      seg      <= SegBlank;
    end else begin
      if (scan_cnt == ScanMax) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_result_seg_display.sv
// Scoreboard bench for result_seg_display: expected BCD values are queued at stimulus time
// and popped by a monitor on each bcd_valid pulse; display and timing are checked directly.
module tb_result_seg_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  result = 9'd0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_pulses = 0;
  logic [11:0] exp_q[$];

  result_seg_display #(.RESULT_W(9), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .result(result), .seg(seg), .an(an), .dp(dp),
    .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
    n_pushed++;
  endtask

  // Monitor: every bcd_valid pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bcd_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {20'b0, bcd}, 32'hFFFF_FFFF);
      end else begin
        check("bcd_scoreboard", {20'b0, bcd}, {20'b0, exp_q.pop_front()});
      end
    end
  end

  // Watches a full frame; each slot's seg must match its digit.
  task automatic check_display(input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: e = e0;
        4'b1101: e = e1;
        4'b1011: e = e2;
        4'b0111: e = e3;
        default: begin
          e = 7'bx;
          check("an_onehot", {28'b0, an}, 32'h0);
        end
      endcase
      if (e !== 7'bx) check("seg_digit", {25'b0, seg}, {25'b0, e});
      check("dp_off", {31'b0, dp}, 32'd1);
    end
  endtask

  task automatic run_conv(input logic [8:0] v, input logic [11:0] e);
    bit seen = 0;
    push(e);
    @(negedge clk);
    result = v;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) seen = 1;
    end
    check("valid_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values and idle display of "0"
    #12;
    check("rst_seg", {25'b0, seg}, {25'b0, SB});
    check("rst_an", {28'b0, an}, 32'hF);
    check("rst_bcd", {20'b0, bcd}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, bcd_valid}, 32'd0);
    check("rst_dp", {31'b0, dp}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    // 5: scan order and slot timing with REFRESH_DIV=4
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("scan_an", {28'b0, an}, {28'b0, ~(4'b0001 << ((k - 1) / 4))});
      check("scan_seg", {25'b0, seg}, {25'b0, (k <= 4) ? S0 : SB});
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_valid", {31'b0, bcd_valid}, 32'd0);
    end

    // 2: 255 with cycle-exact busy/valid timing
    push(12'h255);
    result = 9'd255;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      check("t2_busy", {31'b0, busy}, {31'b0, (k <= 9)});
      check("t2_valid", {31'b0, bcd_valid}, {31'b0, (k == 10)});
    end
    check_display(S5, S5, S2, SB);

    // 3: 511 then 7
    run_conv(9'd511, 12'h511);
    check_display(S1, S1, S5, SB);
    run_conv(9'd7, 12'h007);
    check_display(S7, SB, SB, SB);

    // 4: change mid-conversion; latest value converted afterwards
    push(12'h100);
    push(12'h042);
    result = 9'd100;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      check("t4_valid", {31'b0, bcd_valid}, {31'b0, (k == 10 || k == 21)});
      if (k == 2) result = 9'd42;
    end
    check_display(S2, S4, SB, SB);

    // 6: reset mid-conversion of 300
    result = 9'd300;
    for (int k = 0; k <= 4; k++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_an", {28'b0, an}, 32'hF);
    check("t6_seg", {25'b0, seg}, {25'b0, SB});
    check("t6_bcd", {20'b0, bcd}, 32'h0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_rst_valid", {31'b0, bcd_valid}, 32'd0);
    end
    push(12'h300);
    reset_n = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      check("t6_valid", {31'b0, bcd_valid}, {31'b0, (k == 10)});
    end
    check_display(S0, S0, S3, SB);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("pulse_count", n_pulses, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
